timer_core: RTL
===============

# timer_core

Pulse-width timer RTL driven by the timer bus-functional model. Edge-detects `start` and `capture`, runs a free-incrementing counter between them, snapshots the elapsed clock count into `captured`, and raises a sticky `alarm_out` when the running count hits a programmed value. It sits behind the timer BFM in the bench and in the design wherever interval measurement is needed.

## Interface
- `WIDTH`, 32, counter/capture/alarm width
- `clk`  in  1  timer clock (122 MHz nominal)
- `rst_an`  in  1  asynchronous, active-low reset
- `rst_capture`  in  1  synchronous level clear of `captured`
- `start`  in  1  start request; rising edge (re)starts measurement
- `capture`  in  1  capture request; rising edge snapshots and stops
- `alarm_en`  in  1  alarm compare enable (level)
- `alarm`  in  WIDTH  alarm compare value
- `captured`  out  WIDTH  last snapshot: clocks from start edge to capture edge
- `counter`  out  WIDTH  live counter value
- `alarm_out`  out  1  sticky alarm flag
- `running`  out  1  high while in RUN

## Operation
- Edge detect: `start_re = start & ~start_d`, `capture_re = capture & ~capture_d`; `start_d`/`capture_d` are registered. Multi-cycle pulses count as one edge.
- FSM states: IDLE, RUN, STOPPED.
  - IDLE: `counter` holds 0. `start_re` -> RUN, `counter <= 0`.
  - RUN: `counter <= counter + 1` each edge. `capture_re` -> STOPPED, `captured <= counter + 1`, `counter <= counter + 1`. `start_re` -> stays RUN, `counter <= 0`.
  - STOPPED: `counter` frozen. `start_re` -> RUN, `counter <= 0`. `capture_re` is ignored.
- `capture_re` in IDLE or STOPPED has no effect.
- Same-edge `start_re` and `capture_re`: start wins. The block restarts and `captured` is unchanged.
- Arithmetic is unsigned modulo 2^WIDTH. Counter wraps `FFFF_FFFF` -> 0 without a flag. `captured` uses the same wrap.
- `rst_capture` high at an edge: `captured <= 0`. This overrides a same-edge capture.
- Alarm:
  - `alarm_out <= 1` at an edge where `alarm_en` and state is RUN and `counter == alarm` (registered compare).
  - Sticky until an edge with `alarm_en == 0` or `start_re`.
  - `start_re` clears it and has priority over a same-edge set.
- `running` equals (state == RUN).

## Timing
- Reset (`rst_an` low, asynchronous): state IDLE, `counter = 0`, `captured = 0`, `alarm_out = 0`, `running = 0`, `start_d = capture_d = 0`.
- Reset release is synchronous to `clk` through the usual deassertion synchronizer.
- Reset mid-measurement: everything above returns to its reset value immediately, and no snapshot is taken.
- Start edge sampled at edge E1: `counter = 0` after E1, and `counter = k-1` after edge Ek.
- Capture edge sampled W edges after the start edge: `captured = W` after that edge.
  - The BFM pulse task with width W therefore yields `captured == W`.
- `alarm_out` rises one edge after `counter` shows `alarm`. With `alarm = 0` it rises at the edge following the start edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `timer_pkg`: `TIMER_WIDTH = 32`, `typedef enum logic [1:0] {IDLE, RUN, STOPPED} timer_state_t`.
- Sub-module `timer_edge_det`: one register plus rising-edge output, with async active-low reset. It is instantiated twice, for `start` and `capture`.
- Top `timer_core` holds the FSM, counter, capture register and alarm logic. Target size is about 150–250 lines.

## Test plan
- **Basic pulse:** reset, then pulse task with W = 5 -> `captured == 5`, `counter` frozen at 5, `running == 0`. Repeat with W = 1 -> `captured == 1`.
- **Long start pulse:** start held 4 cycles, capture 10 edges after the start edge -> single restart, `captured == 10`.
- **Restart while running:** second start edge 3 cycles into RUN -> `counter` back to 0, and `captured` reflects the distance from the second start only.
- **Alarm:** `alarm_en = 1`, `alarm = 7`, start -> `alarm_out` rises one edge after `counter == 7` and stays high through capture. `alarm_en = 0` -> cleared next edge. Also with `alarm = 0` -> fires on the edge after start.
- **Edge cases:**
  - Same-edge start and capture -> restart, `captured` unchanged.
  - `rst_capture` pulse -> `captured == 0`.
  - Capture in IDLE -> no change.
  - `rst_an` low mid-RUN -> all outputs 0 immediately.
- **Wrap:** force `counter` to `FFFF_FFFE` in RUN, capture 3 edges later -> `counter == 1`, and `captured` equals the start-relative modulo value.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared width and FSM state encoding for the pulse-width timer.
package timer_pkg;

  localparam int TIMER_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_edge_det.sv
// Rising-edge detector: one history register; a held-high input yields a single pulse.
module timer_edge_det (
  input  logic clk,
  input  logic rst_an,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/timer_core.sv
// Pulse-width timer: counts clocks from a start edge to a capture edge,
// with a sticky compare alarm while running.
module timer_core
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_an,
  input  logic             rst_capture,
  input  logic             start,
  input  logic             capture,
  input  logic             alarm_en,
  input  logic [WIDTH-1:0] alarm,
  output logic [WIDTH-1:0] captured,
  output logic [WIDTH-1:0] counter,
  output logic             alarm_out,
  output logic             running
);

  // Assertion is immediate; deassertion is retimed to clk over two flops.
  logic rst_meta_q;
  logic rst_sync_q;
  logic rst_n_int;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n_int = rst_sync_q;

  logic start_re;
  logic capture_re;

  timer_edge_det u_start_det (
    .clk    (clk),
    .rst_an (rst_n_int),
    .sig_i  (start),
    .rise_o (start_re)
  );

  timer_edge_det u_capture_det (
    .clk    (clk),
    .rst_an (rst_n_int),
    .sig_i  (capture),
    .rise_o (capture_re)
  );

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] captured_q, captured_d;
  logic             alarm_q, alarm_d;
  logic             running_q, running_d;
  logic [WIDTH-1:0] counter_inc;

  assign counter_inc = counter_q + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    captured_d = captured_q;

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (start_re) begin
          state_d = RUN;
        end
      end
      RUN: begin
        counter_d = counter_inc;
        // Start beats a same-edge capture: restart and leave the snapshot alone.
        if (start_re) begin
          counter_d = '0;
        end else if (capture_re) begin
          state_d    = STOPPED;
          captured_d = counter_inc;
        end
      end
      STOPPED: begin
        if (start_re) begin
          state_d   = RUN;
          counter_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    if (rst_capture) begin
      captured_d = '0;
    end
  end

  always_comb begin
    alarm_d = alarm_q;
    if (start_re || !alarm_en) begin
      alarm_d = 1'b0;
    end else if (state_q == RUN && counter_q == alarm) begin
      alarm_d = 1'b1;
    end
  end

  assign running_d = (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      captured_q <= '0;
      alarm_q    <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      captured_q <= captured_d;
      alarm_q    <= alarm_d;
      running_q  <= running_d;
    end
  end

  assign captured  = captured_q;
  assign counter   = counter_q;
  assign alarm_out = alarm_q;
  assign running   = running_q;

endmodule
